// File: rtl/axis_event_serializer_pkg.sv
// Shared constants, FSM state type and word-select helper for the event serializer.
// Words leave an event in ascending 32-bit slices: data low, data high, time low, time high.
package axis_event_serializer_pkg;

   localparam int EVENT_WIDTH     = 128;
   localparam int WORD_WIDTH      = 32;
   localparam int WORDS_PER_EVENT = 4;

   localparam logic [1:0]  LAST_IDX     = 2'(WORDS_PER_EVENT - 1);
   localparam logic [31:0] DROP_CNT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   function automatic logic [WORD_WIDTH-1:0] event_word(input logic [EVENT_WIDTH-1:0] ev,
                                                        input logic [1:0] idx);
      return ev[int'(idx) * WORD_WIDTH +: WORD_WIDTH];
   endfunction

endpackage

// File: rtl/axis_event_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered occupancy count.
// The head entry is readable combinationally so the serializer can load it on the pop edge.
module axis_event_fifo #(
   parameter int WIDTH      = 128,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      data_i,
   input  logic                  pop_i,
   output logic [WIDTH-1:0]      data_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   level_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic                  do_push, do_pop;

   // Full is taken from the registered level only, so a same-cycle pop never frees a slot.
   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/axis_event_serializer.sv
// Buffers 128-bit detector events and emits each as four 32-bit AXI4-Stream words.
// Optional TLAST generation is enabled by defining AXIS_EVENT_SERIALIZER_TLAST_EN.
module axis_event_serializer
   import axis_event_serializer_pkg::*;
#(
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [EVENT_WIDTH-1:0]     s_axis_tdata,
   input  logic                       s_axis_tvalid,
   output logic [WORD_WIDTH-1:0]      m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   input  logic                       cfg_clear,
   output logic [31:0]                sts_dropped,
   output logic [FIFO_DEPTH_LOG2:0]   sts_level
);

   logic [EVENT_WIDTH-1:0] fifo_head;
   logic                   fifo_full, fifo_empty, fifo_pop;
   logic                   drop;

   state_e                 state_q, state_d;
   logic [1:0]             idx_q, idx_d;
   logic [EVENT_WIDTH-1:0] out_q, out_d;
   logic                   tvalid_q, tvalid_d;
   logic [WORD_WIDTH-1:0]  tdata_q, tdata_d;
   logic [31:0]            drop_cnt_q, drop_cnt_d;

   axis_event_fifo #(
      .WIDTH      (EVENT_WIDTH),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk     (aclk),
      .rst_n   (aresetn),
      .push_i  (s_axis_tvalid),
      .data_i  (s_axis_tdata),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (sts_level)
   );

   assign drop = s_axis_tvalid & fifo_full;

   // While tvalid_q is high, idx_q always names the word currently on tdata_q.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      out_d    = out_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            tvalid_d = 1'b0;
            if (!fifo_empty) begin
               out_d    = fifo_head;
               fifo_pop = 1'b1;
               idx_d    = 2'd0;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (!tvalid_q) begin
               tvalid_d = 1'b1;
               tdata_d  = event_word(out_q, idx_q);
            end else if (m_axis_tready) begin
               if (idx_q == LAST_IDX) begin
                  idx_d = 2'd0;
                  if (!fifo_empty) begin
                     // Reload straight from the FIFO head so the next event follows without a bubble.
                     out_d    = fifo_head;
                     fifo_pop = 1'b1;
                     tdata_d  = event_word(fifo_head, 2'd0);
                  end else begin
                     tvalid_d = 1'b0;
                     state_d  = IDLE;
                  end
               end else begin
                  idx_d   = idx_q + 2'd1;
                  tdata_d = event_word(out_q, idx_q + 2'd1);
               end
            end
         end
         default: begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (cfg_clear) begin
         drop_cnt_d = '0;
      end else if (drop && (drop_cnt_q != DROP_CNT_MAX)) begin
         drop_cnt_d = drop_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         out_q      <= '0;
         tvalid_q   <= 1'b0;
         tdata_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         out_q      <= out_d;
         tvalid_q   <= tvalid_d;
         tdata_q    <= tdata_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign sts_dropped   = drop_cnt_q;

`ifdef AXIS_EVENT_SERIALIZER_TLAST_EN
   assign m_axis_tlast = tvalid_q & (idx_q == LAST_IDX);
`else
   assign m_axis_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_axis_event_serializer.sv
// Scoreboard bench for axis_event_serializer: stimulus queues expected words, a monitor checks handshakes.
// Build with or without AXIS_EVENT_SERIALIZER_TLAST_EN; the expected TLAST follows the same macro.
module tb_axis_event_serializer;

   localparam int N = 2;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [127:0]  s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic [31:0]   m_tdata;
   logic          m_tvalid;
   logic          m_tready = 1'b0;
   logic          m_tlast;
   logic          cfg_clear = 1'b0;
   logic [31:0]   sts_dropped;
   logic [N:0]    sts_level;

   int            checks = 0;
   int            errors = 0;
   int            words_acc = 0;
   logic [32:0]   exp_q[$];
   logic [32:0]   mon_e;
   logic          stall_prev = 1'b0;
   logic [31:0]   data_prev = '0;

   axis_event_serializer #(.FIFO_DEPTH_LOG2(N)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .cfg_clear     (cfg_clear),
      .sts_dropped   (sts_dropped),
      .sts_level     (sts_level)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Reference rule: an event is sent as its four 32-bit slices from bit 0 upward, last flag on the fourth.
   task automatic expect_event(input logic [127:0] ev);
      logic last;
      for (int k = 0; k < 4; k++) begin
`ifdef AXIS_EVENT_SERIALIZER_TLAST_EN
         last = (k == 3);
`else
         last = 1'b0;
`endif
         exp_q.push_back({last, ev[32*k +: 32]});
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic drive(input logic [127:0] ev, input logic kept);
      s_tvalid = 1'b1;
      s_tdata  = ev;
      if (kept) expect_event(ev);
      $display("event %032h kept=%0d", ev, kept);
      tick();
   endtask

   function automatic logic [127:0] rand_ev();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic drain();
      int n;
      n = 0;
      m_tready = 1'b1;
      while ((exp_q.size() != 0 || m_tvalid) && n < 300) begin
         tick();
         n++;
      end
      chk("drain_done", {63'd0, (exp_q.size() == 0 && !m_tvalid)}, 64'd1);
   endtask

   task automatic wait_word2();
      int n;
      n = 0;
      while (!(m_tvalid && m_tdata == 32'd2) && n < 20) begin
         tick();
         n++;
      end
      chk("reach_word2", {63'd0, m_tvalid && m_tdata == 32'd2}, 64'd1);
   endtask

   always @(negedge aclk) begin
      if (!aresetn) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_valid", {63'd0, m_tvalid}, 64'd1);
            chk("hold_data", {32'd0, m_tdata}, {32'd0, data_prev});
         end
         if (m_tvalid && m_tready) begin
            $display("word %08h last=%0d", m_tdata, m_tlast);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_word: got %08h required none", m_tdata);
            end else begin
               mon_e = exp_q.pop_front();
               chk("word_data", {32'd0, m_tdata}, {32'd0, mon_e[31:0]});
               chk("word_last", {63'd0, m_tlast}, {63'd0, mon_e[32]});
            end
            words_acc++;
         end
         stall_prev = m_tvalid && !m_tready;
         data_prev  = m_tdata;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] ev;
      int base_w, pushed;

      ev = 128'h00000004_00000003_00000002_00000001;
      tick(); tick(); tick();
      chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
      chk("rst_tdata", {32'd0, m_tdata}, 64'd0);
      chk("rst_tlast", {63'd0, m_tlast}, 64'd0);
      chk("rst_dropped", {32'd0, sts_dropped}, 64'd0);
      chk("rst_level", {61'd0, sts_level}, 64'd0);
      aresetn = 1'b1;
      tick();

      // Single event: latency and consecutive words
      m_tready = 1'b1;
      drive(ev, 1'b1);
      s_tvalid = 1'b0;
      chk("lat_e0_level", {61'd0, sts_level}, 64'd1);
      chk("lat_e0_valid", {63'd0, m_tvalid}, 64'd0);
      tick();
      chk("lat_e1_valid", {63'd0, m_tvalid}, 64'd0);
      tick();
      chk("lat_e2_valid", {63'd0, m_tvalid}, 64'd1);
      chk("lat_e2_data", {32'd0, m_tdata}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("single_valid", {63'd0, m_tvalid}, 64'd1);
      end
      tick();
      chk("single_end", {63'd0, m_tvalid}, 64'd0);

      // Backpressure while word 2 is presented
      drive(ev, 1'b1);
      s_tvalid = 1'b0;
      wait_word2();
      m_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_valid", {63'd0, m_tvalid}, 64'd1);
         chk("bp_data", {32'd0, m_tdata}, 64'd2);
      end
      drain();

      // Overflow: one event in the output register, four in the FIFO, sixth dropped
      m_tready = 1'b0;
      for (int i = 0; i < 6; i++) drive(rand_ev(), i < 5);
      s_tvalid = 1'b0;
      tick();
      chk("ovf_dropped", {32'd0, sts_dropped}, 64'd1);
      chk("ovf_level", {61'd0, sts_level}, 64'd4);
      drain();

      // Clear wins over a same-cycle drop, then counting resumes
      m_tready = 1'b0;
      for (int i = 0; i < 5; i++) drive(rand_ev(), 1'b1);
      cfg_clear = 1'b1;
      drive(rand_ev(), 1'b0);
      cfg_clear = 1'b0;
      s_tvalid  = 1'b0;
      chk("clr_drop", {32'd0, sts_dropped}, 64'd0);
      drive(rand_ev(), 1'b0);
      s_tvalid = 1'b0;
      chk("recount", {32'd0, sts_dropped}, 64'd1);

      // Saturation at all-ones
      force dut.drop_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.drop_cnt_q;
      drive(rand_ev(), 1'b0);
      s_tvalid = 1'b0;
      chk("sat_drop", {32'd0, sts_dropped}, 64'hFFFF_FFFF);
      tick();
      chk("sat_idle", {32'd0, sts_dropped}, 64'hFFFF_FFFF);
      cfg_clear = 1'b1;
      tick();
      cfg_clear = 1'b0;
      chk("sat_clear", {32'd0, sts_dropped}, 64'd0);
      drain();

      // Back-to-back: two queued events give eight valid words without a bubble
      m_tready = 1'b0;
      drive(rand_ev(), 1'b1);
      drive(rand_ev(), 1'b1);
      s_tvalid = 1'b0;
      tick(); tick(); tick();
      chk("b2b_level", {61'd0, sts_level}, 64'd1);
      m_tready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk("b2b_valid", {63'd0, m_tvalid}, 64'd1);
         tick();
      end
      chk("b2b_end", {63'd0, m_tvalid}, 64'd0);
      chk("b2b_empty", exp_q.size(), 64'd0);

      // Asynchronous reset in the middle of an event
      drive(ev, 1'b1);
      s_tvalid = 1'b0;
      wait_word2();
      #2;
      aresetn = 1'b0;
      #1;
      chk("arst_tvalid", {63'd0, m_tvalid}, 64'd0);
      chk("arst_tdata", {32'd0, m_tdata}, 64'd0);
      chk("arst_tlast", {63'd0, m_tlast}, 64'd0);
      exp_q.delete();
      tick(); tick();
      aresetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("post_rst_level", {61'd0, sts_level}, 64'd0);
      end
      chk("post_rst_valid", {63'd0, m_tvalid}, 64'd0);

      // Random traffic with outstanding events kept below FIFO capacity
      base_w = words_acc;
      pushed = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         m_tready = ($urandom_range(0, 3) != 0);
         if ((pushed - (words_acc - base_w) / 4) < 4 && $urandom_range(0, 2) == 0) begin
            drive(rand_ev(), 1'b1);
            pushed++;
         end else begin
            s_tvalid = 1'b0;
            tick();
         end
      end
      s_tvalid = 1'b0;
      drain();
      chk("rand_no_drop", {32'd0, sts_dropped}, 64'd0);
      chk("rand_words", words_acc - base_w, 64'(pushed * 4));
      chk("queue_empty", exp_q.size(), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
